// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode tracker: prefix parsing, key-map lookup, held-key mask and event FIFO.
// Define PS2_KEY_TRACKER_EXT_EN to compile in E0-prefix handling and ext-bit matching.
module ps2_key_tracker #(
    parameter int unsigned NUM_KEYS = 8,
    parameter logic [9*NUM_KEYS-1:0] KEY_MAP =
        {9'h042, 9'h03B, 9'h033, 9'h034, 9'h02B, 9'h023, 9'h01B, 9'h01C},
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic [NUM_KEYS-1:0] key_mask,
    output logic                any_pressed,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] evt_index,
    output logic                evt_make,
    output logic                evt_overflow
);

    localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [7:0]  BYTE_BRK = 8'hF0;
    localparam logic [7:0]  BYTE_EXT = 8'hE0;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             make;
    } evt_t;

`ifdef PS2_KEY_TRACKER_EXT_EN
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    logic code_ext;
`else
    typedef enum logic {IDLE, BRK} state_t;
`endif

    state_t state, state_n;
    logic   code_done, code_brk;

    logic [NUM_KEYS-1:0] hit_vec;
    logic [IDX_W-1:0]    hit_idx;
    logic                hit, held, do_make, do_break, push;
    evt_t                push_evt;

    evt_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic             full, pop, push_ok;
    evt_t             head_n;

    // Prefix parser state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Prefix parser: flags a completed code and whether it is a break / extended
    always_comb begin
        state_n   = state;
        code_done = 1'b0;
        code_brk  = 1'b0;
`ifdef PS2_KEY_TRACKER_EXT_EN
        code_ext  = 1'b0;
`endif
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == BYTE_BRK) begin
                        state_n = BRK;
                    end else if (rx_data == BYTE_EXT) begin
`ifdef PS2_KEY_TRACKER_EXT_EN
                        state_n = EXT;
`endif
                    end else begin
                        code_done = 1'b1;
                    end
                end
                BRK: begin
                    if (rx_data == BYTE_BRK) begin
                        state_n = BRK;
                    end else if (rx_data == BYTE_EXT) begin
`ifdef PS2_KEY_TRACKER_EXT_EN
                        state_n = EXT_BRK;
`endif
                    end else begin
                        code_done = 1'b1;
                        code_brk  = 1'b1;
                        state_n   = IDLE;
                    end
                end
`ifdef PS2_KEY_TRACKER_EXT_EN
                EXT: begin
                    if (rx_data == BYTE_BRK) begin
                        state_n = EXT_BRK;
                    end else if (rx_data != BYTE_EXT) begin
                        code_done = 1'b1;
                        code_ext  = 1'b1;
                        state_n   = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (rx_data != BYTE_BRK && rx_data != BYTE_EXT) begin
                        code_done = 1'b1;
                        code_brk  = 1'b1;
                        code_ext  = 1'b1;
                        state_n   = IDLE;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // Key-map lookup; scanning downwards leaves the lowest matching index
    always_comb begin
        logic ext_ok;
        hit_vec = '0;
        hit_idx = '0;
        ext_ok  = 1'b1;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
`ifdef PS2_KEY_TRACKER_EXT_EN
            ext_ok = (KEY_MAP[9*i+8] == code_ext);
`endif
            if (rx_data == KEY_MAP[9*i +: 8] && ext_ok) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
                hit_idx    = IDX_W'(i);
            end
        end
    end

    assign hit      = |hit_vec;
    assign held     = |(hit_vec & key_mask);
    assign do_make  = code_done && !code_brk && hit && !held;
    assign do_break = code_done && code_brk && held;
    assign push     = do_make || do_break;
    assign push_evt = '{index: hit_idx, make: do_make};

    always_ff @(posedge clk) begin
        if (reset) begin
            key_mask    <= '0;
            any_pressed <= 1'b0;
        end else begin
            if (do_make)       key_mask <= key_mask | hit_vec;
            else if (do_break) key_mask <= key_mask & ~hit_vec;
            any_pressed <= |key_mask;
        end
    end

    // Event FIFO; head is registered and bypassed from the push when it lands on the read slot
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = evt_valid && evt_ready;
    assign push_ok  = push && (!full || pop);
    assign rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        count_n = count;
        if (push_ok && !pop)      count_n = count + CNT_W'(1);
        else if (!push_ok && pop) count_n = count - CNT_W'(1);
        head_n = mem[rd_ptr_n];
        if (push_ok && rd_ptr_n == wr_ptr) head_n = push_evt;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_valid    <= 1'b0;
            evt_index    <= '0;
            evt_make     <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            evt_valid <= (count_n != '0);
            if (count_n != '0) begin
                evt_index <= head_n.index;
                evt_make  <= head_n.make;
            end
            if (push && full && !pop) evt_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with the default key map and FIFO depth.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] key_mask;
    logic       any_pressed;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_index;
    logic       evt_make;
    logic       evt_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_key_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .key_mask     (key_mask),
        .any_pressed  (any_pressed),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_index    (evt_index),
        .evt_make     (evt_make),
        .evt_overflow (evt_overflow)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pop_expect(input string tag, input logic [2:0] idx, input logic mk);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_index"}, 32'(evt_index), 32'(idx));
        check({tag, "_make"},  32'(evt_make),  32'(mk));
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; evt_ready = 1'b0;
        repeat (2) tick();
        check("rst_mask",     32'(key_mask),     32'h00);
        check("rst_any",      32'(any_pressed),  32'd0);
        check("rst_valid",    32'(evt_valid),    32'd0);
        check("rst_overflow", 32'(evt_overflow), 32'd0);
        check("rst_index",    32'(evt_index),    32'd0);
        check("rst_make",     32'(evt_make),     32'd0);
        reset = 1'b0;

        // Two makes then a break
        send(8'h1C);
        check("first_evt_latency", 32'(evt_valid), 32'd1);
        send(8'h1B);
        check("mk2_mask", 32'(key_mask), 32'h03);
        tick();
        check("mk2_any", 32'(any_pressed), 32'd1);
        send(8'hF0); send(8'h1C);
        check("brk_mask", 32'(key_mask), 32'h02);
        pop_expect("seq_e0", 3'd0, 1'b1);
        pop_expect("seq_e1", 3'd1, 1'b1);
        pop_expect("seq_e2", 3'd0, 1'b0);
        check("seq_empty", 32'(evt_valid), 32'd0);
        send(8'hF0); send(8'h1B);
        pop_expect("rel1", 3'd1, 1'b0);
        tick();
        check("rel_any", 32'(any_pressed), 32'd0);

        // Typematic repeat
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("typ_mask", 32'(key_mask), 32'h01);
        pop_expect("typ_e0", 3'd0, 1'b1);
        check("typ_single", 32'(evt_valid), 32'd0);
        send(8'hF0); send(8'h1C);
        pop_expect("typ_rel", 3'd0, 1'b0);

        // Overflow with a stalled consumer
        send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
        check("ovf_not_yet", 32'(evt_overflow), 32'd0);
        send(8'h33);
        check("ovf_flag", 32'(evt_overflow), 32'd1);
        check("ovf_mask", 32'(key_mask), 32'h3E);
        tick();
        check("ovf_head_stable", 32'(evt_index), 32'd1);
        pop_expect("ovf_e0", 3'd1, 1'b1);
        pop_expect("ovf_e1", 3'd2, 1'b1);
        pop_expect("ovf_e2", 3'd3, 1'b1);
        pop_expect("ovf_e3", 3'd4, 1'b1);
        check("ovf_empty", 32'(evt_valid), 32'd0);
        check("ovf_sticky", 32'(evt_overflow), 32'd1);

        // Reset mid-prefix discards the pending F0
        send(8'hF0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_overflow", 32'(evt_overflow), 32'd0);
        check("midrst_mask0", 32'(key_mask), 32'h00);
        send(8'h1B);
        check("midrst_mask", 32'(key_mask), 32'h02);
        pop_expect("midrst_e0", 3'd1, 1'b1);

        // Unmapped codes and breaks of keys not held
        send(8'hAA);
        check("unmap_valid", 32'(evt_valid), 32'd0);
        check("unmap_mask", 32'(key_mask), 32'h02);
        send(8'hF0); send(8'h5A);
        check("unmap_brk_valid", 32'(evt_valid), 32'd0);
        send(8'hF0); send(8'h1C);
        check("nothld_valid", 32'(evt_valid), 32'd0);
        check("nothld_mask", 32'(key_mask), 32'h02);
        send(8'hF0); send(8'hF0); send(8'h1B);
        check("dblf0_mask", 32'(key_mask), 32'h00);
        pop_expect("dblf0_e0", 3'd1, 1'b0);

        // E0 prefix: ext mismatch under EXT_EN, discarded otherwise
        send(8'hE0); send(8'h1C);
`ifdef PS2_KEY_TRACKER_EXT_EN
        check("ext_mask", 32'(key_mask), 32'h00);
        check("ext_valid", 32'(evt_valid), 32'd0);
`else
        check("ext_mask", 32'(key_mask), 32'h01);
        pop_expect("ext_e0", 3'd0, 1'b1);
`endif

        // Push and pop in the same cycle while full
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        rx_valid = 1'b1; rx_data = 8'h34; evt_ready = 1'b1;
        tick();
        rx_valid = 1'b0; evt_ready = 1'b0;
        check("full_pp_overflow", 32'(evt_overflow), 32'd0);
        check("full_pp_mask", 32'(key_mask), 32'h1F);
        pop_expect("full_pp_e0", 3'd1, 1'b1);
        pop_expect("full_pp_e1", 3'd2, 1'b1);
        pop_expect("full_pp_e2", 3'd3, 1'b1);
        pop_expect("full_pp_e3", 3'd4, 1'b1);
        check("full_pp_empty", 32'(evt_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
